// File: rtl/mult_m_seq.sv
// Sequential 5x5 signed matrix multiplier: one multiply-accumulate per clock,
// packed row-major operands/result (element 0 at MSBs), sticky overflow flag.
module mult_m_seq #(
    parameter int unsigned N     = 5,
    parameter int unsigned W     = 8,
    parameter int unsigned ACC_W = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [N*N*W-1:0]     lin,
    input  logic [N*N*W-1:0]     col,
    output logic                 busy,
    output logic                 done,
    output logic [N*N*W-1:0]     n_out,
    output logic                 ovf
);

    localparam int unsigned TOT_W = N * N * W;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned OFF_W = $clog2(TOT_W);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_e;

    state_e                   state_q, state_d;
    logic [IDX_W-1:0]         i_q, i_d;
    logic [IDX_W-1:0]         j_q, j_d;
    logic [IDX_W-1:0]         k_q, k_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [TOT_W-1:0]         a_q, a_d;
    logic [TOT_W-1:0]         b_q, b_d;
    logic [TOT_W-1:0]         res_q, res_d;
    logic                     ovf_q, ovf_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    int unsigned              a_lin, b_lin, o_lin;
    logic [OFF_W-1:0]         a_off, b_off, o_off;
    logic signed [W-1:0]      a_el, b_el;
    logic signed [2*W-1:0]    prod;
    logic signed [ACC_W-1:0]  sum;
    logic                     sum_ovr;

    // MAC datapath: select A[i][k] and B[k][j], accumulate into the full-width sum
    always_comb begin
        a_lin   = N * 32'(i_q) + 32'(k_q);
        b_lin   = N * 32'(k_q) + 32'(j_q);
        o_lin   = N * 32'(i_q) + 32'(j_q);
        a_off   = OFF_W'(TOT_W - 1 - W * a_lin);
        b_off   = OFF_W'(TOT_W - 1 - W * b_lin);
        o_off   = OFF_W'(TOT_W - 1 - W * o_lin);
        a_el    = a_q[a_off -: W];
        b_el    = b_q[b_off -: W];
        prod    = a_el * b_el;
        sum     = acc_q + ACC_W'(prod);
        // In range for W bits only when all bits from W-1 upward agree with the sign
        sum_ovr = !((&sum[ACC_W-1:W-1]) || !(|sum[ACC_W-1:W-1]));
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = lin;
                    b_d     = col;
                    res_d   = '0;
                    ovf_d   = 1'b0;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    acc_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (k_q != LAST) begin
                    acc_d = sum;
                    k_d   = k_q + IDX_W'(1);
                end else begin
                    res_d[o_off -: W] = sum[W-1:0];
                    ovf_d = ovf_q | sum_ovr;
                    acc_d = '0;
                    k_d   = '0;
                    if (j_q != LAST) begin
                        j_d = j_q + IDX_W'(1);
                    end else begin
                        j_d = '0;
                        if (i_q == LAST) begin
                            i_d     = '0;
                            state_d = S_DONE;
                        end else begin
                            i_d = i_q + IDX_W'(1);
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_CALC);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign n_out = res_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_mult_m_seq.sv
// Bench for mult_m_seq: cycle-count/matrix-product model checked every cycle,
// plus directed runs with hand-computed literal results.
module tb_mult_m_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         abort;
    logic [199:0] lin;
    logic [199:0] col;
    logic         busy;
    logic         done;
    logic [199:0] n_out;
    logic         ovf;

    int checks   = 0;
    int failures = 0;

    mult_m_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .abort (abort),
        .lin   (lin),
        .col   (col),
        .busy  (busy),
        .done  (done),
        .n_out (n_out),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference product from plain integer arithmetic
    task automatic model_mult(input logic [199:0] a, input logic [199:0] b,
                              output logic [199:0] r, output logic o);
        int s;
        logic [7:0] ea, eb;
        r = '0;
        o = 1'b0;
        for (int rr = 0; rr < 5; rr++) begin
            for (int cc = 0; cc < 5; cc++) begin
                s = 0;
                for (int kk = 0; kk < 5; kk++) begin
                    ea = 8'(a >> (8 * (24 - (5 * rr + kk))));
                    eb = 8'(b >> (8 * (24 - (5 * kk + cc))));
                    s += int'($signed(ea)) * int'($signed(eb));
                end
                if (s > 127 || s < -128) o = 1'b1;
                r = (r << 8) | 200'(8'(s));
            end
        end
    endtask

    function automatic logic [199:0] ident();
        logic [199:0] r = '0;
        for (int e = 0; e < 25; e++) r = (r << 8) | 200'((e / 5 == e % 5) ? 1 : 0);
        return r;
    endfunction

    // Model: cycles since accepted start (0 idle, 1..125 busy, 126 done)
    int           m_cyc;
    logic         m_valid;
    logic [199:0] m_res;
    logic         m_ovf;
    logic [199:0] r_tmp;
    logic         o_tmp;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cyc   <= 0;
            m_valid <= 1'b1;
            m_res   <= '0;
            m_ovf   <= 1'b0;
        end else if (m_cyc == 0) begin
            if (start) begin
                model_mult(lin, col, r_tmp, o_tmp);
                m_res   <= r_tmp;
                m_ovf   <= o_tmp;
                m_valid <= 1'b0;
                m_cyc   <= 1;
            end
        end else if (m_cyc <= 125) begin
            if (abort) begin
                m_cyc <= 0;
            end else begin
                m_cyc <= m_cyc + 1;
                if (m_cyc == 125) m_valid <= 1'b1;
            end
        end else begin
            m_cyc <= 0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            chk("busy", 200'(busy), 200'(m_cyc >= 1 && m_cyc <= 125));
            chk("done", 200'(done), 200'(m_cyc == 126));
            if (m_valid) begin
                chk("n_out", n_out, m_res);
                chk("ovf", 200'(ovf), 200'(m_ovf));
            end
        end
    end

    // Start a run (entered at a negedge) and wait for done; optional mid-run restart
    task automatic run(input logic [199:0] a, input logic [199:0] b, input logic with_abort,
                       input int restart_at, output int cyc, output int bcnt);
        lin   = a;
        col   = b;
        start = 1'b1;
        abort = with_abort;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        cyc   = 0;
        bcnt  = 0;
        while (!done && cyc < 300) begin
            if (busy) bcnt++;
            if (cyc + 1 == restart_at) begin
                start = 1'b1;
                lin   = ~a;
                col   = {25{8'h33}};
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
    endtask

    task automatic finish_run(input string name, input int cyc, input int bcnt,
                              input logic [199:0] exp_res, input logic exp_ovf);
        chk({name, "_latency"}, 200'(cyc), 200'(125));
        chk({name, "_busy_cycles"}, 200'(bcnt), 200'(125));
        chk({name, "_result"}, n_out, exp_res);
        chk({name, "_ovf"}, 200'(ovf), 200'(exp_ovf));
        @(negedge clk);
        chk({name, "_done_drop"}, 200'(done), 200'(0));
    endtask

    localparam logic [199:0] SEQ = 200'h0102030405060708090A0B0C0D0E0F10111213141516171819;

    initial begin
        int cyc, bcnt, dcnt;
        logic [199:0] id;
        id    = ident();
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        lin   = '0;
        col   = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 200'(busy), 200'(0));
        chk("rst_done", 200'(done), 200'(0));
        chk("rst_n_out", n_out, 200'(0));
        chk("rst_ovf", 200'(ovf), 200'(0));
        rst = 1'b0;
        @(negedge clk);

        run(id, SEQ, 1'b0, 0, cyc, bcnt);
        finish_run("ident", cyc, bcnt, SEQ, 1'b0);

        run({25{8'h01}}, {25{8'h01}}, 1'b1, 0, cyc, bcnt);
        finish_run("ones", cyc, bcnt, {25{8'h05}}, 1'b0);

        run({25{8'h7F}}, {25{8'h7F}}, 1'b0, 0, cyc, bcnt);
        finish_run("max_pos", cyc, bcnt, {25{8'h05}}, 1'b1);

        run({25{8'hFF}}, id, 1'b0, 0, cyc, bcnt);
        finish_run("neg_one", cyc, bcnt, {25{8'hFF}}, 1'b0);

        run({25{8'h80}}, {25{8'h80}}, 1'b0, 0, cyc, bcnt);
        finish_run("min_neg", cyc, bcnt, 200'(0), 1'b1);

        run(id, SEQ, 1'b0, 40, cyc, bcnt);
        finish_run("restart", cyc, bcnt, SEQ, 1'b0);
        dcnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("restart_single_done", 200'(dcnt), 200'(0));

        // Abort at cycle 60
        lin   = id;
        col   = SEQ;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (59) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 200'(busy), 200'(0));
        dcnt = 0;
        repeat (140) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("abort_no_done", 200'(dcnt), 200'(0));

        run(id, {25{8'h02}}, 1'b0, 0, cyc, bcnt);
        finish_run("after_abort", cyc, bcnt, {25{8'h02}}, 1'b0);

        // Reset at cycle 30
        lin   = id;
        col   = SEQ;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_busy", 200'(busy), 200'(0));
        chk("midrst_done", 200'(done), 200'(0));
        chk("midrst_n_out", n_out, 200'(0));
        chk("midrst_ovf", 200'(ovf), 200'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", 200'(busy), 200'(0));

        run(id, SEQ, 1'b0, 0, cyc, bcnt);
        finish_run("post_rst", cyc, bcnt, SEQ, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
